// File: rtl/ndiag_scheduler_if.sv
// Handshake bundle between the four BU requesters, the shared diag/non-diag
// compute unit and the round-robin scheduler that arbitrates between them.
interface ndiag_scheduler_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req;
  logic [DATA_W-1:0] op0;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] op3;
  logic              unit_done;
  logic [DATA_W-1:0] unit_result;
  logic              unit_start;
  logic [DATA_W-1:0] unit_operand;
  logic [3:0]        ack;
  logic [1:0]        grant_id;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_err;
  logic              busy;

  // Requester/compute-unit side.
  modport master (
    output req, op0, op1, op2, op3, unit_done, unit_result,
    input  unit_start, unit_operand, ack, grant_id, result,
           result_valid, result_err, busy
  );

  // Scheduler side.
  modport slave (
    input  req, op0, op1, op2, op3, unit_done, unit_result,
    output unit_start, unit_operand, ack, grant_id, result,
           result_valid, result_err, busy
  );
endinterface

// File: rtl/ndiag_scheduler.sv
// Round-robin scheduler sharing one diag/non-diag compute unit among four
// requesters, with a watchdog that aborts a transaction when the unit hangs.
module ndiag_scheduler #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               areset,
  ndiag_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        wd_cnt_q, wd_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              unit_start_q, unit_start_d;
  logic [3:0]        ack_q, ack_d;
  logic              result_valid_q, result_valid_d;
  logic              result_err_q, result_err_d;
  logic              busy_q, busy_d;
  logic [2:0]        pick_s;

  // Returns {found, index}; the lowest offset from ptr wins, so scan downwards.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  function automatic logic [DATA_W-1:0] op_sel(
    input logic [1:0]        idx,
    input logic [DATA_W-1:0] o0,
    input logic [DATA_W-1:0] o1,
    input logic [DATA_W-1:0] o2,
    input logic [DATA_W-1:0] o3
  );
    logic [DATA_W-1:0] sel;
    case (idx)
      2'd0:    sel = o0;
      2'd1:    sel = o1;
      2'd2:    sel = o2;
      2'd3:    sel = o3;
      default: sel = '0;
    endcase
    return sel;
  endfunction

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge areset) begin
    if (!areset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= 2'd0;
      wd_cnt_q       <= 8'd0;
      err_q          <= 1'b0;
      grant_q        <= 2'd0;
      operand_q      <= '0;
      result_q       <= '0;
      unit_start_q   <= 1'b0;
      ack_q          <= 4'd0;
      result_valid_q <= 1'b0;
      result_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      wd_cnt_q       <= wd_cnt_d;
      err_q          <= err_d;
      grant_q        <= grant_d;
      operand_q      <= operand_d;
      result_q       <= result_d;
      unit_start_q   <= unit_start_d;
      ack_q          <= ack_d;
      result_valid_q <= result_valid_d;
      result_err_q   <= result_err_d;
      busy_q         <= busy_d;
    end
  end

  // Next state and datapath; unit_done only matters in WAIT, where it beats the watchdog.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wd_cnt_d  = wd_cnt_q;
    err_d     = err_q;
    grant_d   = grant_q;
    operand_d = operand_q;
    result_d  = result_q;
    pick_s    = rr_pick(bus.req, rr_ptr_q);
    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          state_d   = ISSUE;
          grant_d   = pick_s[1:0];
          operand_d = op_sel(pick_s[1:0], bus.op0, bus.op1, bus.op2, bus.op3);
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wd_cnt_d = 8'd0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (bus.unit_done) begin
          result_d = bus.unit_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      RESP: begin
        rr_ptr_d = grant_q + 2'd1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output strobes are decoded from the next state so they register alongside it.
  always_comb begin
    unit_start_d   = 1'b0;
    ack_d          = 4'd0;
    result_valid_d = 1'b0;
    result_err_d   = 1'b0;
    busy_d         = 1'b1;
    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end
      ISSUE: begin
        unit_start_d = 1'b1;
      end
      WAIT: begin
        busy_d = 1'b1;
      end
      RESP: begin
        ack_d          = 4'b0001 << grant_d;
        result_valid_d = 1'b1;
        result_err_d   = err_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.unit_start   = unit_start_q;
  assign bus.unit_operand = operand_q;
  assign bus.ack          = ack_q;
  assign bus.grant_id     = grant_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_err   = result_err_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/ndiag_scheduler.md
# ndiag_scheduler

Shares the single diagonal/non-diagonal compute unit among four operand requesters (BU1..BU4) in the UKF covariance datapath. It arbitrates round-robin between pending requests and drives a one-cycle start pulse with the granted operand. It then waits for the unit's done, guarded by a watchdog, and returns the result with a per-requester acknowledge. It replaces fixed-order sequencing: idle requesters are skipped and a hung unit cannot stall the pipeline.

## Interface
- DATA_W, 32, operand/result width
- TIMEOUT, 255, max WAIT cycles before abort (1..255)

- clock  in  1  system clock, rising edge
- areset  in  1  asynchronous reset, active-low (asserted when 0)
- req  in  4  request per requester; bit i = BUi+1; held until ack
- op0, op1, op2, op3  in  DATA_W each  operand per requester; stable while req high
- unit_done  in  1  compute unit completion pulse
- unit_result  in  DATA_W  compute unit result, valid with unit_done
- unit_start  out  1  one-cycle start pulse to compute unit
- unit_operand  out  DATA_W  latched operand of granted requester
- ack  out  4  one-hot, one-cycle acknowledge to granted requester
- grant_id  out  2  index of current/last granted requester
- result  out  DATA_W  registered result, valid with result_valid
- result_valid  out  1  one-cycle result strobe, same cycle as ack
- result_err  out  1  1 with result_valid when watchdog aborted; result = 0
- busy  out  1  1 whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registered state; all outputs registered.
- Internal state: rr_ptr (2 bits), wd_cnt (8 bits).
- IDLE: if req != 0, grant the first set bit searching rr_ptr, rr_ptr+1, ... mod 4. Latch grant_id and op[grant] into unit_operand. Go ISSUE. Otherwise stay.
- ISSUE: unit_start = 1 for exactly this cycle; clear wd_cnt; go WAIT.
- WAIT: on unit_done, latch unit_result into result, clear err, go RESP. Else if wd_cnt == TIMEOUT-1, set err, result = 0, go RESP. Else wd_cnt++.
- RESP: ack[grant_id] = 1, result_valid = 1, result_err = err. rr_ptr <= grant_id+1 (wraps 3->0). Go IDLE.
- unit_done is ignored outside WAIT, including in the ISSUE cycle.
- unit_done coinciding with the timeout cycle: done wins, so no error.
- unit_operand holds its value from ISSUE until the next grant. result holds until the next RESP.
- req changes outside IDLE do not affect the current transaction.

## Timing
- Reset (areset = 0), asynchronous:
  - state = IDLE, rr_ptr = 0, wd_cnt = 0.
  - Outputs: unit_start, ack, result_valid, result_err, busy, grant_id, unit_operand, result all 0.
- Reset mid-transaction aborts with no ack and no result. Requesters must re-request.
- Req sampled high in IDLE at cycle 0 gives:
  - busy = 1 and grant_id valid from cycle 1
  - unit_start in cycle 1
  - unit_done earliest sampled in cycle 2
  - ack/result_valid in the cycle after done is sampled (min cycle 3)
- Minimum request-to-request spacing is 4 cycles (IDLE, ISSUE, WAIT, RESP). Back-to-back grants are possible with no extra idle cycle beyond IDLE.
- Timeout: with no done, RESP occurs TIMEOUT cycles after entering WAIT, at cycle TIMEOUT+2 from the grant.
- Requesters drop req in the cycle after ack. A req still high in that IDLE cycle is a new request; rr_ptr has already moved past it.

## Test plan
- Single request: req = 0b0001, op0 = 0x3F800000; unit_done after 3 WAIT cycles with unit_result = 0x40000000. Expected: unit_start in cycle 1, unit_operand = 0x3F800000, ack = 0b0001 and result = 0x40000000 with result_err = 0.
- Round-robin fairness: req = 0b1111 held continuously, unit answers in 1 cycle. Expected grants 0, 1, 2, 3, 0, each ack one-hot for one cycle, with 4-cycle spacing.
- Skip idle requesters: req = 0b1010, rr_ptr = 0. Expected grant 1 then 3, then 1 again if still requested. Requesters 0 and 2 are never acked.
- Watchdog: TIMEOUT = 8, unit_done never asserted. Expected result_valid and result_err = 1 and result = 0 exactly 10 cycles after the grant, with ack to the granted requester. Done exactly on the 8th WAIT cycle gives result_err = 0.
- Spurious done: unit_done pulsed in IDLE and in the ISSUE cycle. Expected no state change; the transaction completes only on a later done.
- Reset mid-WAIT: areset = 0 for 1 cycle during WAIT. Expected all outputs 0 immediately and no ack; after release, a pending req is granted starting from requester 0.
